pipe_stall_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 35 +++
 rtl/pipe_stall_ctrl_lu_detect.sv | 15 +
 rtl/pipe_stall_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and constants for the pipeline stall/flush sequencer.
// The control bundle struct keeps every output decision in one assignment.
package pipe_ctrl_pkg;

    localparam int REG_W         = 4;
    localparam int MD_CYCLES_DEF = 8;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MD_WAIT = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;

    typedef struct packed {
        logic wr_pc;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic idex_write;
        logic exmem_bubble;
        logic md_go;
        logic md_done;
        logic halt;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{wr_pc: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
                                       default: 1'b0};

    // Everything frozen and NOPs injected while the core is held in reset.
    localparam ctrl_t CTRL_RESET   = '{ifid_flush: 1'b1, idex_bubble: 1'b1, idex_write: 1'b1,
                                       exmem_bubble: 1'b1, default: 1'b0};

    localparam ctrl_t CTRL_MD_STALL = '{exmem_bubble: 1'b1, default: 1'b0};

    localparam ctrl_t CTRL_ID_HOLD  = '{idex_bubble: 1'b1, idex_write: 1'b1, default: 1'b0};

endpackage

// File: rtl/pipe_stall_ctrl_lu_detect.sv
// Load-use hazard comparator: the load in EX writes a register the ID instruction reads.
// Kept separate so the forwarding unit can reuse it.
module lu_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] idRegR1,
    input  logic [REG_W-1:0] idRegR2,
    input  logic [REG_W-1:0] exRegRd,
    input  logic             exMemRead,
    output logic             loadUse
);

    assign loadUse = exMemRead && ((idRegR1 == exRegRd) || (idRegR2 == exRegRd));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: resolves branch flush, mul/div stall, load-use stall and HALT/resume
// and drives the PC and pipeline-register enables from one small FSM.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEF,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] idRegR1,
    input  logic [REG_W-1:0] idRegR2,
    input  logic [REG_W-1:0] exRegRd,
    input  logic             exMemRead,
    input  logic             exMdOp,
    input  logic             branchTaken,
    input  logic             idHalt,
    input  logic             resume,
    output logic             wrPC,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXBubble,
    output logic             IDEXWrite,
    output logic             EXMEMBubble,
    output logic             mdGo,
    output logic             mdDone,
    output logic             halt
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    ctrl_t            ctrl;

    lu_detect u_lu_detect (
        .idRegR1   (idRegR1),
        .idRegR2   (idRegR2),
        .exRegRd   (exRegRd),
        .exMemRead (exMemRead),
        .loadUse   (load_use)
    );

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        ctrl    = CTRL_DEFAULT;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (branchTaken) begin
                    ctrl.ifid_flush  = 1'b1;
                    ctrl.idex_bubble = 1'b1;
                end else if (exMdOp) begin
                    ctrl       = CTRL_MD_STALL;
                    ctrl.md_go = 1'b1;
                    cnt_d      = CNT_W'(MD_CYCLES - 1);
                    state_d    = ST_MD_WAIT;
                end else if (load_use) begin
                    ctrl = CTRL_ID_HOLD;
                end else if (idHalt) begin
                    ctrl    = CTRL_ID_HOLD;
                    state_d = ST_HALTED;
                end
            end
            ST_MD_WAIT: begin
                if (cnt_q != '0) begin
                    ctrl  = CTRL_MD_STALL;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    ctrl.md_done = 1'b1;
                    state_d      = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    // The held HALT is dropped from IF/ID as fetch restarts.
                    ctrl.ifid_flush = 1'b1;
                    state_d         = ST_RUN;
                end else begin
                    ctrl      = CTRL_ID_HOLD;
                    ctrl.halt = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (!rst_n) begin
            ctrl = CTRL_RESET;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wrPC        = ctrl.wr_pc;
    assign IFIDWrite   = ctrl.ifid_write;
    assign IFIDFlush   = ctrl.ifid_flush;
    assign IDEXBubble  = ctrl.idex_bubble;
    assign IDEXWrite   = ctrl.idex_write;
    assign EXMEMBubble = ctrl.exmem_bubble;
    assign mdGo        = ctrl.md_go;
    assign mdDone      = ctrl.md_done;
    assign halt        = ctrl.halt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: two instances (MD_CYCLES 8 and 2) share stimulus; a cycle-level
// reference model checks both every cycle, and directed sequences pin literal expectations.
module tb_pipe_stall_ctrl;

    // Output vector order: wrPC IFIDWrite IFIDFlush IDEXBubble IDEXWrite EXMEMBubble mdGo mdDone halt
    localparam logic [8:0] V_DEF    = 9'b110010000;
    localparam logic [8:0] V_RST    = 9'b001111000;
    localparam logic [8:0] V_BR     = 9'b111110000;
    localparam logic [8:0] V_GO     = 9'b000001100;
    localparam logic [8:0] V_STALL  = 9'b000001000;
    localparam logic [8:0] V_DONE   = 9'b110010010;
    localparam logic [8:0] V_HOLD   = 9'b000110000;
    localparam logic [8:0] V_HALTED = 9'b000110001;
    localparam logic [8:0] V_RESUME = 9'b111010000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] idRegR1, idRegR2, exRegRd;
    logic       exMemRead, exMdOp, branchTaken, idHalt, resume;

    logic wrPC_a, IFIDWrite_a, IFIDFlush_a, IDEXBubble_a, IDEXWrite_a, EXMEMBubble_a, mdGo_a, mdDone_a, halt_a;
    logic wrPC_b, IFIDWrite_b, IFIDFlush_b, IDEXBubble_b, IDEXWrite_b, EXMEMBubble_b, mdGo_b, mdDone_b, halt_b;
    logic [8:0] out_a, out_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MD_CYCLES(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .idRegR1(idRegR1), .idRegR2(idRegR2), .exRegRd(exRegRd),
        .exMemRead(exMemRead), .exMdOp(exMdOp), .branchTaken(branchTaken), .idHalt(idHalt),
        .resume(resume), .wrPC(wrPC_a), .IFIDWrite(IFIDWrite_a), .IFIDFlush(IFIDFlush_a),
        .IDEXBubble(IDEXBubble_a), .IDEXWrite(IDEXWrite_a), .EXMEMBubble(EXMEMBubble_a),
        .mdGo(mdGo_a), .mdDone(mdDone_a), .halt(halt_a)
    );

    pipe_stall_ctrl #(.MD_CYCLES(2), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .idRegR1(idRegR1), .idRegR2(idRegR2), .exRegRd(exRegRd),
        .exMemRead(exMemRead), .exMdOp(exMdOp), .branchTaken(branchTaken), .idHalt(idHalt),
        .resume(resume), .wrPC(wrPC_b), .IFIDWrite(IFIDWrite_b), .IFIDFlush(IFIDFlush_b),
        .IDEXBubble(IDEXBubble_b), .IDEXWrite(IDEXWrite_b), .EXMEMBubble(EXMEMBubble_b),
        .mdGo(mdGo_b), .mdDone(mdDone_b), .halt(halt_b)
    );

    assign out_a = {wrPC_a, IFIDWrite_a, IFIDFlush_a, IDEXBubble_a, IDEXWrite_a, EXMEMBubble_a,
                    mdGo_a, mdDone_a, halt_a};
    assign out_b = {wrPC_b, IFIDWrite_b, IFIDFlush_b, IDEXBubble_b, IDEXWrite_b, EXMEMBubble_b,
                    mdGo_b, mdDone_b, halt_b};

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: tracks only "halted", "waiting for mul/div" and the absolute cycle
    // at which the mul/div releases the pipeline.
    int  cyc = 0;
    int  md_len[2] = '{8, 2};
    bit  m_halted[2];
    bit  m_in_md[2];
    int  m_release[2];

    function automatic logic [8:0] model_step(input int k);
        bit lu;
        lu = exMemRead && (idRegR1 == exRegRd || idRegR2 == exRegRd);
        if (!rst_n) begin
            m_halted[k] = 1'b0;
            m_in_md[k]  = 1'b0;
            return V_RST;
        end
        if (m_in_md[k]) begin
            if (cyc < m_release[k]) return V_STALL;
            m_in_md[k] = 1'b0;
            return V_DONE;
        end
        if (m_halted[k]) begin
            if (resume) begin
                m_halted[k] = 1'b0;
                return V_RESUME;
            end
            return V_HALTED;
        end
        if (branchTaken) return V_BR;
        if (exMdOp) begin
            m_in_md[k]   = 1'b1;
            m_release[k] = cyc + md_len[k];
            return V_GO;
        end
        if (lu) return V_HOLD;
        if (idHalt) begin
            m_halted[k] = 1'b1;
            return V_HOLD;
        end
        return V_DEF;
    endfunction

    always @(negedge clk) begin
        logic [8:0] exp_a, exp_b;
        exp_a = model_step(0);
        exp_b = model_step(1);
        check("model_md8", out_a, exp_a);
        check("model_md2", out_b, exp_b);
        cyc++;
    end

    task automatic idle_inputs();
        idRegR1 = 4'd1; idRegR2 = 4'd2; exRegRd = 4'd0;
        exMemRead = 1'b0; exMdOp = 1'b0; branchTaken = 1'b0; idHalt = 1'b0; resume = 1'b0;
    endtask

    // Check both instances at the negedge of the current cycle, then advance one cycle.
    task automatic expect_cycle(input string name, input logic [8:0] e8, input logic [8:0] e2);
        @(negedge clk);
        check({name, "_md8"}, out_a, e8);
        check({name, "_md2"}, out_b, e2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        expect_cycle("reset_hold", V_RST, V_RST);
        rst_n = 1'b1;
        expect_cycle("after_reset", V_DEF, V_DEF);

        // Load-use: load to R3 in EX, ID reads R3 on its second source.
        exMemRead = 1'b1; exRegRd = 4'd3; idRegR1 = 4'd5; idRegR2 = 4'd3;
        expect_cycle("load_use", V_HOLD, V_HOLD);
        exMemRead = 1'b0;
        expect_cycle("load_use_release", V_DEF, V_DEF);

        // Mul/div: 8-cycle stall on one instance, 2-cycle stall on the other.
        exMdOp = 1'b1;
        expect_cycle("md_go", V_GO, V_GO);
        exMdOp = 1'b0;
        expect_cycle("md_t1", V_STALL, V_STALL);
        expect_cycle("md_t2", V_STALL, V_DONE);
        for (int i = 3; i < 8; i++) expect_cycle("md_tmid", V_STALL, V_DEF);
        expect_cycle("md_t8", V_DONE, V_DEF);
        expect_cycle("md_t9", V_DEF, V_DEF);

        // Branch outranks load-use and HALT; no stall, no state change.
        branchTaken = 1'b1; idHalt = 1'b1; exMemRead = 1'b1; exRegRd = 4'd5; idRegR1 = 4'd5;
        expect_cycle("branch_prio", V_BR, V_BR);
        idle_inputs();
        expect_cycle("branch_after", V_DEF, V_DEF);

        // HALT then resume.
        idHalt = 1'b1;
        expect_cycle("halt_enter", V_HOLD, V_HOLD);
        idHalt = 1'b0;
        for (int i = 0; i < 20; i++) expect_cycle("halted", V_HALTED, V_HALTED);
        resume = 1'b1;
        expect_cycle("resume", V_RESUME, V_RESUME);
        resume = 1'b0;
        expect_cycle("resume_after", V_DEF, V_DEF);

        // Resume in RUN has no effect.
        resume = 1'b1;
        expect_cycle("resume_in_run", V_DEF, V_DEF);
        resume = 1'b0;

        // Reset in the middle of MD_WAIT: no mdDone afterwards.
        exMdOp = 1'b1;
        expect_cycle("md2_go", V_GO, V_GO);
        exMdOp = 1'b0;
        for (int i = 1; i < 4; i++) expect_cycle("md2_wait", V_STALL, (i == 2) ? V_DONE : (i == 1 ? V_STALL : V_DEF));
        rst_n = 1'b0;
        expect_cycle("md_reset_0", V_RST, V_RST);
        expect_cycle("md_reset_1", V_RST, V_RST);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) expect_cycle("md_reset_after", V_DEF, V_DEF);

        // Randomized phase: narrow register range so load-use collisions are frequent.
        for (int i = 0; i < 3000; i++) begin
            idRegR1     = 4'($urandom_range(0, 3));
            idRegR2     = 4'($urandom_range(0, 3));
            exRegRd     = 4'($urandom_range(0, 3));
            exMemRead   = ($urandom_range(0, 99) < 30);
            exMdOp      = ($urandom_range(0, 99) < 6);
            branchTaken = ($urandom_range(0, 99) < 10);
            idHalt      = ($urandom_range(0, 99) < 6);
            resume      = ($urandom_range(0, 99) < 15);
            rst_n       = ($urandom_range(0, 99) >= 1);
            @(posedge clk); #1;
        end

        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
